// File: rtl/vcve2_pkg.sv
// Shared types and helpers for the vector register-file read sequencer.
package vcve2_pkg;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } vsew_e;

  typedef enum logic [1:0] {
    VRD_IDLE,
    VRD_READ,
    VRD_DRAIN,
    VRD_DONE
  } vrd_state_e;

  // Command word counters; vl << 2 rounded up to words never exceeds 32 bits.
  localparam int unsigned VrdCntW = 32;

  // log2 of the element size in bytes; the reserved encoding behaves as 32-bit.
  function automatic logic [1:0] sew_bytes_shift(vsew_e sew);
    case (sew)
      SEW8:    return 2'd0;
      SEW16:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Byte enables of the final word given the residual byte count.
  function automatic logic [3:0] tail_be(logic [1:0] tail);
    case (tail)
      2'd0:    return 4'b1111;
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/vcve2_vrd_fifo2.sv
// Two-entry synchronous FIFO buffering returned VRF read data.
module vcve2_vrd_fifo2 #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= ~wptr_q;
      if (do_pop)  rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/vcve2_vrf_rd_seq.sv
// Streams one vector register (or, with VCVE2_VRF_RD_LMUL_EN, a register group)
// out of the VRF as 32-bit words on a valid/ready stream with byte enables.
module vcve2_vrf_rd_seq
  import vcve2_pkg::*;
#(
  parameter  int unsigned VLEN = 128,
  localparam int unsigned WPR  = VLEN / 32,
  localparam int unsigned AW   = 5 + $clog2(WPR)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [4:0]    vs_i,
  input  logic [31:0]   vl_i,
  input  logic [1:0]    sew_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          vrf_re_o,
  output logic [AW-1:0] vrf_raddr_o,
  input  logic [31:0]   vrf_rdata_i,
  output logic [31:0]   data_o,
  output logic [3:0]    be_o,
  output logic          last_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int unsigned WIW = $clog2(WPR);
  localparam int unsigned CW  = VrdCntW;

  vrd_state_e    state_q, state_d;
  logic [4:0]    vs_q, vs_d;
  logic [CW-1:0] nwords_q, nwords_d;
  logic [1:0]    tail_q, tail_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          inflight_q;

  logic [33:0]   cmd_bytes;
  logic [CW-1:0] cmd_nwords;
  logic [1:0]    cmd_tail;

  always_comb begin
    cmd_bytes  = {2'b00, vl_i} << sew_bytes_shift(vsew_e'(sew_i));
    cmd_tail   = cmd_bytes[1:0];
    cmd_nwords = cmd_bytes[33:2] + CW'(cmd_tail != 2'd0);
`ifdef VCVE2_VRF_RD_LMUL_EN
    // Register groups: the contiguous address increment walks into vs+1, vs+2, ...
    cmd_tail   = cmd_bytes[1:0];
`else
    // Anything past one register is dropped; the clamped final word is full.
    if (cmd_nwords > CW'(WPR)) begin
      cmd_nwords = CW'(WPR);
      cmd_tail   = 2'd0;
    end
`endif
  end

  logic [31:0] fifo_head;
  logic        fifo_full, fifo_empty;
  logic [1:0]  fifo_cnt;
  logic        fifo_push, fifo_pop;
  logic [2:0]  outstanding;
  logic        rd_en, beat, is_last;

  // An empty buffer falls through so returning data is offered the same cycle.
  assign valid_o   = ~fifo_empty | inflight_q;
  assign beat      = valid_o & ready_i;
  assign fifo_pop  = ~fifo_empty & ready_i;
  assign fifo_push = inflight_q & ~(fifo_empty & ready_i);

  assign outstanding = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign rd_en       = (state_q == VRD_READ) && !fifo_full && (outstanding < 3'd2);
  assign is_last     = (out_cnt_q == nwords_q - CW'(1));

  assign vrf_re_o    = rd_en;
  assign vrf_raddr_o = rd_en ? ({vs_q, {WIW{1'b0}}} + rd_cnt_q[AW-1:0]) : '0;

  assign data_o = !valid_o ? 32'd0 : (fifo_empty ? vrf_rdata_i : fifo_head);
  assign last_o = valid_o & is_last;
  assign be_o   = !valid_o ? 4'b0000 : (is_last ? tail_be(tail_q) : 4'b1111);

  vcve2_vrd_fifo2 #(
    .DW (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (vrf_rdata_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    vs_d      = vs_q;
    nwords_d  = nwords_q;
    tail_d    = tail_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    busy_o    = 1'b0;
    done_o    = 1'b0;

    if (beat) out_cnt_d = out_cnt_q + CW'(1);

    unique case (state_q)
      VRD_IDLE: begin
        if (start_i) begin
          vs_d      = vs_i;
          nwords_d  = cmd_nwords;
          tail_d    = cmd_tail;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (cmd_nwords == '0) ? VRD_DONE : VRD_READ;
        end
      end
      VRD_READ: begin
        busy_o = 1'b1;
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == nwords_q - CW'(1)) state_d = VRD_DRAIN;
        end
      end
      VRD_DRAIN: begin
        busy_o = 1'b1;
        if (beat && is_last) state_d = VRD_DONE;
      end
      VRD_DONE: begin
        done_o  = 1'b1;
        state_d = VRD_IDLE;
      end
      default: state_d = VRD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= VRD_IDLE;
      vs_q       <= 5'd0;
      nwords_q   <= '0;
      tail_q     <= 2'd0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      nwords_q   <= nwords_d;
      tail_q     <= tail_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_vcve2_vrf_rd_seq.sv
// Scoreboard bench for vcve2_vrf_rd_seq: expected reads and beats are queued at
// issue time and a negedge monitor checks them as the DUT produces them.
module tb_vcve2_vrf_rd_seq;

  localparam int unsigned VLEN = 128;
  localparam int unsigned WPR  = VLEN / 32;
  localparam int unsigned AW   = 5 + $clog2(WPR);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [4:0]    vs_i;
  logic [31:0]   vl_i;
  logic [1:0]    sew_i;
  logic          busy_o, done_o, vrf_re_o, last_o, valid_o, ready_i;
  logic [AW-1:0] vrf_raddr_o;
  logic [31:0]   vrf_rdata_i, data_o;
  logic [3:0]    be_o;

  vcve2_vrf_rd_seq #(
    .VLEN (VLEN)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start_i),
    .vs_i        (vs_i),
    .vl_i        (vl_i),
    .sew_i       (sew_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .vrf_re_o    (vrf_re_o),
    .vrf_raddr_o (vrf_raddr_o),
    .vrf_rdata_i (vrf_rdata_i),
    .data_o      (data_o),
    .be_o        (be_o),
    .last_o      (last_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int reads_issued, beats_seen, done_cnt, first_valid_cyc, last_beat_cyc, done_cyc, start_edge;
  logic [AW-1:0] addr_q [$];
  beat_t         beat_q [$];
  logic [AW-1:0] exp_a;
  beat_t         exp_b;
  logic          stall_prev;
  logic [31:0]   prev_data;

  function automatic logic [31:0] vrf_word(input logic [AW-1:0] a);
    return 32'hA500_0000 | ({25'd0, a} << 12) | {25'd0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // VRF model: one-cycle read latency, junk when no read was issued.
  initial forever begin
    @(posedge clk);
    vrf_rdata_i <= vrf_re_o ? vrf_word(vrf_raddr_o) : 32'hDEAD_BEEF;
  end

  initial begin
    stall_prev = 1'b0;
    prev_data  = 32'd0;
    done_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (vrf_re_o) begin
          if (addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_read: raddr %0d, none expected (cycle %0d)", vrf_raddr_o, cyc);
          end else begin
            exp_a = addr_q.pop_front();
            check("raddr", 64'(vrf_raddr_o), 64'(exp_a));
          end
          reads_issued++;
          check("outstanding_le2", 64'((reads_issued - beats_seen) <= 2), 64'd1);
        end
        if (stall_prev) begin
          check("stall_valid", 64'(valid_o), 64'd1);
          check("stall_data", 64'(data_o), 64'(prev_data));
        end
        if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (valid_o && ready_i) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: data %0h, none expected (cycle %0d)", data_o, cyc);
          end else begin
            exp_b = beat_q.pop_front();
            check("beat_data", 64'(data_o), 64'(exp_b.data));
            check("beat_be", 64'(be_o), 64'(exp_b.be));
            check("beat_last", 64'(last_o), 64'(exp_b.last));
          end
          beats_seen++;
          last_beat_cyc = cyc;
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        stall_prev = valid_o & ~ready_i;
        prev_data  = data_o;
      end
    end
  end

  // Queue the hand-computed response, then pulse start for one cycle.
  task automatic issue(input logic [4:0] vs, input logic [31:0] vl, input logic [1:0] sew,
                       input int nw, input logic [3:0] last_be);
    logic [AW-1:0] a;
    for (int k = 0; k < nw; k++) begin
      a = AW'(int'(vs) * int'(WPR) + k);
      addr_q.push_back(a);
      beat_q.push_back('{data: vrf_word(a), be: (k == nw - 1) ? last_be : 4'hF,
                         last: (k == nw - 1)});
    end
    reads_issued    = 0;
    beats_seen      = 0;
    first_valid_cyc = -1;
    last_beat_cyc   = -1;
    done_cyc        = -1;
    vs_i    = vs;
    vl_i    = vl;
    sew_i   = sew;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_edge = cyc;
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int  d0  = done_cnt;
    logic got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    check({name, "_reads_left"}, 64'(addr_q.size()), 64'd0);
    check({name, "_beats_left"}, 64'(beat_q.size()), 64'd0);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 100 && beats_seen < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("beats_reached", 64'(beats_seen >= n), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 64'(busy_o), 64'd0);
    check({name, "_done"}, 64'(done_o), 64'd0);
    check({name, "_re"}, 64'(vrf_re_o), 64'd0);
    check({name, "_raddr"}, 64'(vrf_raddr_o), 64'd0);
    check({name, "_valid"}, 64'(valid_o), 64'd0);
    check({name, "_last"}, 64'(last_o), 64'd0);
    check({name, "_be"}, 64'(be_o), 64'd0);
    check({name, "_data"}, 64'(data_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    vs_i    = 5'd0;
    vl_i    = 32'd0;
    sew_i   = 2'd0;
    ready_i = 1'b1;
    reads_issued = 0;
    beats_seen   = 0;
    first_valid_cyc = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // vs=3, 4 x 32-bit: raddr 12..15 back to back, all bytes enabled.
    issue(5'd3, 32'd4, 2'b10, 4, 4'b1111);
    @(negedge clk);
    check("busy_after_start", 64'(busy_o), 64'd1);
    wait_done("w32x4");
    check("w32x4_first_valid", 64'(first_valid_cyc), 64'(start_edge + 1));
    check("w32x4_last_beat", 64'(last_beat_cyc), 64'(start_edge + 4));
    check("w32x4_done_cyc", 64'(done_cyc), 64'(start_edge + 5));
    check("w32x4_reads", 64'(reads_issued), 64'd4);

    // Partial final words: 5 bytes, 6 bytes, 7 bytes; reserved SEW acts as 32-bit.
    issue(5'd5, 32'd5, 2'b00, 2, 4'b0001);
    wait_done("b5");
    issue(5'd7, 32'd3, 2'b01, 2, 4'b0011);
    wait_done("h3");
    issue(5'd2, 32'd7, 2'b00, 2, 4'b0111);
    wait_done("b7");
    issue(5'd1, 32'd3, 2'b11, 3, 4'b1111);
    wait_done("rsvd3");

    // vl=0 finishes immediately without touching the VRF or the stream.
    issue(5'd4, 32'd0, 2'b10, 0, 4'b0000);
    wait_done("vl0");
    check("vl0_done_cyc", 64'(done_cyc), 64'(start_edge));
    check("vl0_reads", 64'(reads_issued), 64'd0);
    check("vl0_no_valid", 64'(first_valid_cyc), 64'(-1));

    // Backpressure for 3 cycles after the first beat; a start meanwhile is ignored.
    issue(5'd6, 32'd4, 2'b10, 4, 4'b1111);
    wait_beats(1);
    ready_i = 1'b0;
    vs_i    = 5'd0;
    vl_i    = 32'd1;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 ready_i = 1'b1;
    wait_done("stall");
    check("stall_reads", 64'(reads_issued), 64'd4);

    // Abort after 2 beats, then a fresh command restarts from word 0.
    issue(5'd8, 32'd4, 2'b10, 4, 4'b1111);
    wait_beats(2);
    rst     = 1'b1;
    ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    ready_i = 1'b1;
    addr_q.delete();
    beat_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done_o), 64'd0);
      check("abort_no_valid", 64'(valid_o), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(5'd8, 32'd4, 2'b10, 4, 4'b1111);
    wait_done("restart");
    check("restart_first_valid", 64'(first_valid_cyc), 64'(start_edge + 1));

    // v31 with vl=8 words: group wraps to address 0..3, single register stops at 4.
`ifdef VCVE2_VRF_RD_LMUL_EN
    issue(5'd31, 32'd8, 2'b10, 8, 4'b1111);
`else
    issue(5'd31, 32'd8, 2'b10, 4, 4'b1111);
`endif
    wait_done("v31");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
